// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory subsystem: unified address map,
// requester IDs and the memory-arbiter state encoding.
package chip8_pkg;

    localparam logic [12:0] RAM_BASE   = 13'h0000;
    localparam logic [12:0] VREG_BASE  = 13'h1000;
    localparam logic [12:0] IREG_HI    = 13'h1010;
    localparam logic [12:0] IREG_LO    = 13'h1011;
    localparam logic [12:0] DT         = 13'h1012;
    localparam logic [12:0] ST         = 13'h1013;
    localparam logic [12:0] PC_HI      = 13'h1014;
    localparam logic [12:0] PC_LO      = 13'h1015;
    localparam logic [12:0] SP         = 13'h1016;
    localparam logic [12:0] STACK_BASE = 13'h1020;

    localparam int REQ_DISP = 0;
    localparam int REQ_CPU  = 1;
    localparam int REQ_SPR  = 2;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/chip8_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after rr_ptr,
// wrapping modulo NUM_REQ; next_ptr points one past the winner.
module chip8_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   next_ptr
);

    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W-1:0]   idx;
    logic               found;

    assign eligible = valid & mask;

    always_comb begin
        grant    = '0;
        next_ptr = rr_ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((int'(idx) + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Shares the single-port CHIP-8 memory BRAM between display, CPU and sprite drawer.
// Define CHIP8_ARB_LOCK_EN to let a requester hold the grant for atomic read-modify-write.
//
// state     | meaning
// ST_ARB    | round-robin among all valid requesters
// ST_LOCKED | only the lock owner may be granted; lock_cnt bounds the hold time
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 2,
    parameter int LOCK_MAX   = 64
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    input  logic [NUM_REQ-1:0]               req_we_in,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr_in,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]               req_lock_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    output logic [NUM_REQ-1:0]               rsp_valid_out,
    output logic [DATA_W-1:0]                rsp_data_out,
    output logic                             bram_en_out,
    output logic                             bram_we_out,
    output logic [ADDR_W-1:0]                bram_addr_out,
    output logic [DATA_W-1:0]                bram_data_out,
    input  logic [DATA_W-1:0]                bram_data_in,
    output logic                             error_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = 1 + RD_LATENCY;

    logic [PTR_W-1:0]            rr_ptr;
    logic [PTR_W-1:0]            next_ptr;
    logic [PTR_W-1:0]            g_idx;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          mask;
    logic                        hs;
    logic [DEPTH-1:0]            tag_v;
    logic [DEPTH-1:0][PTR_W-1:0] tag_id;

`ifdef CHIP8_ARB_LOCK_EN
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    arb_state_t       state;
    logic [PTR_W-1:0] owner;
    logic [CNT_W-1:0] lock_cnt;
    logic             error_q;

    always_comb begin
        mask = '1;
        if (state == ST_LOCKED) begin
            mask        = '0;
            mask[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= ST_ARB;
            owner    <= '0;
            lock_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (hs && req_lock_in[g_idx]) begin
                        state    <= ST_LOCKED;
                        owner    <= g_idx;
                        lock_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                        state   <= ST_ARB;
                        error_q <= 1'b1;
                    end else if (!req_lock_in[owner] && (hs || !req_valid_in[owner])) begin
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    assign error_out = error_q;
`else
    logic unused_lock;

    assign unused_lock = (^req_lock_in) ^ (LOCK_MAX == 0);
    assign mask        = '1;
    assign error_out   = 1'b0;
`endif

    chip8_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .valid    (req_valid_in),
        .mask     (mask),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // Ready is combinational, so hold it low while reset is asserted.
    assign req_ready_out = grant & {NUM_REQ{rst_n_in}};
    assign hs            = |req_ready_out;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) g_idx = PTR_W'(i);
        end
    end

    // While locked, rr_ptr already sits one past the owner, so release needs no extra update.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr        <= '0;
            bram_en_out   <= 1'b0;
            bram_we_out   <= 1'b0;
            bram_addr_out <= '0;
            bram_data_out <= '0;
            tag_v         <= '0;
            tag_id        <= '0;
        end else begin
            rr_ptr        <= next_ptr;
            bram_en_out   <= hs;
            bram_we_out   <= hs & req_we_in[g_idx];
            bram_addr_out <= hs ? req_addr_in[g_idx] : '0;
            bram_data_out <= hs ? req_data_in[g_idx] : '0;
            tag_v         <= {tag_v[DEPTH-2:0], hs & ~req_we_in[g_idx]};
            tag_id        <= {tag_id[DEPTH-2:0], g_idx};
        end
    end

    always_comb begin
        rsp_valid_out = '0;
        rsp_data_out  = '0;
        if (tag_v[DEPTH-1]) begin
            rsp_valid_out[tag_id[DEPTH-1]] = 1'b1;
            rsp_data_out                   = bram_data_in;
        end
    end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter with a behavioural BRAM and a
// transaction-level reference model (grant order, shadow memory, response queue).
module tb_chip8_mem_arbiter;
    import chip8_pkg::*;

    localparam int NUM_REQ    = 3;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 8;
    localparam int RD_LATENCY = 2;
    localparam int LOCK_MAX   = 64;

    logic                           clk_in = 1'b0;
    logic                           rst_n_in = 1'b1;
    logic [NUM_REQ-1:0]             req_valid_in, req_we_in, req_lock_in;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data_in;
    logic [NUM_REQ-1:0]             req_ready_out, rsp_valid_out;
    logic [DATA_W-1:0]              rsp_data_out, bram_data_out, bram_data_in;
    logic                           bram_en_out, bram_we_out, error_out;
    logic [ADDR_W-1:0]              bram_addr_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    chip8_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RD_LATENCY(RD_LATENCY), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_we_in(req_we_in),
        .req_addr_in(req_addr_in), .req_data_in(req_data_in),
        .req_lock_in(req_lock_in), .req_ready_out(req_ready_out),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
        .bram_en_out(bram_en_out), .bram_we_out(bram_we_out),
        .bram_addr_out(bram_addr_out), .bram_data_out(bram_data_out),
        .bram_data_in(bram_data_in), .error_out(error_out)
    );

    function automatic logic [7:0] init_byte(int a);
        return 8'((a * 29 + 91) ^ (a >> 5));
    endfunction

    // Behavioural BRAM: RD_LATENCY cycles from en/addr to dout, with a backdoor write port.
    logic [7:0]  bram_mem [8192];
    logic [7:0]  rd_pipe [RD_LATENCY];
    bit          filled = 1'b0;
    logic        bd_we = 1'b0;
    logic [12:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    always @(posedge clk_in) begin
        if (!filled) begin
            for (int a = 0; a < 8192; a++) bram_mem[a] <= init_byte(a);
            filled <= 1'b1;
        end else if (bd_we) begin
            bram_mem[bd_addr] <= bd_data;
        end else if (bram_en_out && bram_we_out) begin
            bram_mem[bram_addr_out] <= bram_data_out;
        end
        for (int k = RD_LATENCY - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        rd_pipe[0] <= bram_mem[bram_addr_out];
    end
    assign bram_data_in = rd_pipe[RD_LATENCY-1];

    // Reference model
    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } rsp_t;

    logic [7:0]  m_mem [8192];
    int          m_ptr, m_cyc;
    logic        p_en, p_we;
    logic [12:0] p_addr;
    logic [7:0]  p_data;
    rsp_t        rq[$];

    function automatic int pick();
        for (int k = 0; k < NUM_REQ; k++) begin
            int i = (m_ptr + k) % NUM_REQ;
            if (req_valid_in[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cyc = 0;
        p_en = 0; p_we = 0; p_addr = '0; p_data = '0;
        rq.delete();
    endtask

    task automatic model_predict(output logic [2:0] e_rdy, output logic [2:0] e_rv,
                                 output logic [7:0] e_rd);
        int g = pick();
        e_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        e_rv  = 3'b000;
        e_rd  = 8'h00;
        if (rq.size() > 0 && rq[0].due == m_cyc) begin
            e_rv = 3'(1 << rq[0].id);
            e_rd = rq[0].data;
        end
    endtask

    task automatic model_commit();
        int g = pick();
        if (rq.size() > 0 && rq[0].due == m_cyc) void'(rq.pop_front());
        p_en = (g >= 0); p_we = 1'b0; p_addr = '0; p_data = '0;
        if (g >= 0) begin
            p_we   = req_we_in[g];
            p_addr = req_addr_in[g];
            p_data = req_data_in[g];
            m_ptr  = (g + 1) % NUM_REQ;
            if (req_we_in[g]) m_mem[req_addr_in[g]] = req_data_in[g];
            else rq.push_back('{m_cyc + 1 + RD_LATENCY, g, m_mem[req_addr_in[g]]});
        end
        m_cyc++;
    endtask

    task automatic tick();
        model_commit();
        @(negedge clk_in);
    endtask

    task automatic set_idle();
        req_valid_in = '0; req_we_in = '0; req_lock_in = '0;
        req_addr_in = '0; req_data_in = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
    endtask

    task automatic bd_write(input logic [12:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(posedge clk_in);
        #1 bd_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic test_reset();
        set_idle();
        #2 rst_n_in = 1'b0;
        req_valid_in = 3'b111;
        req_addr_in[1] = 13'h0123;
        @(negedge clk_in);
        #1;
        n_checks++; if (req_ready_out !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready_out); end
        n_checks++; if (rsp_valid_out !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 000", rsp_valid_out); end
        n_checks++; if (rsp_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 00", rsp_data_out); end
        n_checks++; if (bram_en_out !== 1'b0) begin n_fail++; $display("FAIL reset_bram_en: got %b expected 0", bram_en_out); end
        n_checks++; if (bram_we_out !== 1'b0) begin n_fail++; $display("FAIL reset_bram_we: got %b expected 0", bram_we_out); end
        n_checks++; if (bram_addr_out !== 13'h0) begin n_fail++; $display("FAIL reset_bram_addr: got %h expected 0", bram_addr_out); end
        n_checks++; if (bram_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_bram_data: got %h expected 00", bram_data_out); end
        n_checks++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error_out); end
    endtask

    task automatic test_single_read();
        set_idle();
        rst_n_in = 1'b0;
        bd_write(13'h0200, 8'hA2);
        do_reset();
        req_valid_in = 3'b010; req_addr_in[REQ_CPU] = 13'h0200;
        #1;
        n_checks++; if (req_ready_out !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b expected 010", req_ready_out); end
        tick();
        set_idle();
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c == 1) begin
                n_checks++; if (bram_en_out !== 1'b1 || bram_we_out !== 1'b0 || bram_addr_out !== 13'h0200) begin
                    n_fail++; $display("FAIL single_cmd: got en=%b we=%b addr=%h expected en=1 we=0 addr=0200", bram_en_out, bram_we_out, bram_addr_out);
                end
            end
            if (c == 3) begin
                n_checks++; if (rsp_valid_out !== 3'b010 || rsp_data_out !== 8'hA2) begin
                    n_fail++; $display("FAIL single_rsp: got valid=%b data=%h expected valid=010 data=a2", rsp_valid_out, rsp_data_out);
                end
            end else begin
                n_checks++; if (rsp_valid_out !== 3'b000) begin
                    n_fail++; $display("FAIL single_no_rsp cyc %0d: got %b expected 000", c, rsp_valid_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 9) begin
                req_valid_in = 3'b111;
                for (int i = 0; i < NUM_REQ; i++) req_addr_in[i] = 13'(13'h0100 + i);
            end else begin
                set_idle();
            end
            #1;
            if (c < 9) begin
                n_checks++; if (req_ready_out !== 3'(1 << (c % 3))) begin
                    n_fail++; $display("FAIL fair_grant cyc %0d: got %b expected %b", c, req_ready_out, 3'(1 << (c % 3)));
                end
            end
            if (c >= 3) begin
                n_checks++; if (rsp_valid_out !== 3'(1 << ((c - 3) % 3)) || rsp_data_out !== m_mem[13'h0100 + (c - 3) % 3]) begin
                    n_fail++; $display("FAIL fair_rsp cyc %0d: got %b/%h expected %b/%h", c, rsp_valid_out, rsp_data_out,
                                       3'(1 << ((c - 3) % 3)), m_mem[13'h0100 + (c - 3) % 3]);
                end
            end
            tick();
        end
    endtask

    task automatic test_raw();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_idle();
            if (c == 0) begin
                req_valid_in = 3'b010; req_we_in = 3'b010;
                req_addr_in[REQ_CPU] = 13'h1005; req_data_in[REQ_CPU] = 8'h55;
            end else if (c == 1) begin
                req_valid_in = 3'b001; req_addr_in[REQ_DISP] = 13'h1005;
            end
            #1;
            if (c < 2) begin
                n_checks++; if (req_ready_out !== req_valid_in) begin
                    n_fail++; $display("FAIL raw_ready cyc %0d: got %b expected %b", c, req_ready_out, req_valid_in);
                end
            end
            if (c == 4) begin
                n_checks++; if (rsp_valid_out !== 3'b001 || rsp_data_out !== 8'h55) begin
                    n_fail++; $display("FAIL raw_rsp: got %b/%h expected 001/55", rsp_valid_out, rsp_data_out);
                end
            end else begin
                n_checks++; if (rsp_valid_out !== 3'b000) begin
                    n_fail++; $display("FAIL raw_no_rsp cyc %0d: got %b expected 000", c, rsp_valid_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [2:0] e_rdy, e_rv;
        logic [7:0] e_rd;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid_in[i] = (c < 394) && ($urandom_range(0, 99) < 60);
                req_we_in[i]    = ($urandom_range(0, 99) < 35);
                req_addr_in[i]  = ($urandom_range(0, 1) == 1) ? 13'(13'h1000 + $urandom_range(0, 15))
                                                              : 13'(13'h0200 + $urandom_range(0, 15));
                req_data_in[i]  = 8'($urandom);
            end
            #1;
            model_predict(e_rdy, e_rv, e_rd);
            n_checks++; if (req_ready_out !== e_rdy) begin
                n_fail++; $display("FAIL rand_ready cyc %0d: got %b expected %b", c, req_ready_out, e_rdy);
            end
            n_checks++; if ({bram_en_out, bram_we_out, bram_addr_out, bram_data_out} !== {p_en, p_we, p_addr, p_data}) begin
                n_fail++; $display("FAIL rand_cmd cyc %0d: got en=%b we=%b a=%h d=%h expected en=%b we=%b a=%h d=%h", c,
                                   bram_en_out, bram_we_out, bram_addr_out, bram_data_out, p_en, p_we, p_addr, p_data);
            end
            n_checks++; if (rsp_valid_out !== e_rv) begin
                n_fail++; $display("FAIL rand_rsp_valid cyc %0d: got %b expected %b", c, rsp_valid_out, e_rv);
            end
            if (e_rv != 3'b000) begin
                n_checks++; if (rsp_data_out !== e_rd) begin
                    n_fail++; $display("FAIL rand_rsp_data cyc %0d: got %h expected %h", c, rsp_data_out, e_rd);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid_in = 3'b010; req_addr_in[REQ_CPU] = 13'h0200;
        tick();
        set_idle();
        req_valid_in = 3'b100; req_addr_in[REQ_SPR] = 13'h0300;
        tick();
        set_idle();
        req_valid_in = 3'b010;
        rst_n_in = 1'b0;
        #1;
        n_checks++; if ({req_ready_out, rsp_valid_out, rsp_data_out, bram_en_out, bram_we_out, bram_addr_out, bram_data_out, error_out} !== '0) begin
            n_fail++; $display("FAIL midflight_reset_outputs: got rdy=%b rv=%b rd=%h en=%b we=%b a=%h d=%h err=%b expected all 0",
                               req_ready_out, rsp_valid_out, rsp_data_out, bram_en_out, bram_we_out, bram_addr_out, bram_data_out, error_out);
        end
        @(negedge clk_in);
        set_idle();
        rst_n_in = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (rsp_valid_out !== 3'b000) begin
                n_fail++; $display("FAIL midflight_no_rsp cyc %0d: got %b expected 000", c, rsp_valid_out);
            end
            tick();
        end
    endtask

`ifdef CHIP8_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            set_idle();
            if (c == 0) begin
                req_valid_in = 3'b100; req_lock_in = 3'b100; req_addr_in[REQ_SPR] = 13'h0300;
            end else if (c < 5) begin
                req_valid_in = 3'b010; req_lock_in = 3'b100;
            end else if (c == 5) begin
                req_valid_in = 3'b110; req_we_in = 3'b100;
                req_addr_in[REQ_SPR] = 13'h0300; req_data_in[REQ_SPR] = 8'h5A;
            end else begin
                req_valid_in = 3'b010;
            end
            #1;
            begin
                logic [2:0] exp;
                exp = (c == 0 || c == 5) ? 3'b100 : (c == 6) ? 3'b010 : 3'b000;
                n_checks++; if (req_ready_out !== exp) begin
                    n_fail++; $display("FAIL lock_ready cyc %0d: got %b expected %b", c, req_ready_out, exp);
                end
            end
            tick();
        end
        n_checks++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL lock_error: got %b expected 0", error_out); end
    endtask

    task automatic test_lock_timeout();
        do_reset();
        for (int c = 0; c < 70; c++) begin
            set_idle();
            if (c == 0) begin
                req_valid_in = 3'b100; req_lock_in = 3'b100;
            end else begin
                req_valid_in = 3'b010; req_lock_in = (c <= 65) ? 3'b100 : 3'b000;
            end
            #1;
            if (c >= 1 && c <= 64) begin
                n_checks++; if (req_ready_out !== 3'b000 || error_out !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_hold cyc %0d: got rdy=%b err=%b expected 000/0", c, req_ready_out, error_out);
                end
            end else if (c >= 65) begin
                n_checks++; if (req_ready_out !== 3'b010 || error_out !== 1'b1) begin
                    n_fail++; $display("FAIL timeout_release cyc %0d: got rdy=%b err=%b expected 010/1", c, req_ready_out, error_out);
                end
            end
            tick();
        end
        set_idle();
        rst_n_in = 1'b0;
        #1;
        n_checks++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL timeout_error_clear: got %b expected 0", error_out); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask
`endif

    initial begin
        set_idle();
        for (int a = 0; a < 8192; a++) m_mem[a] = init_byte(a);
        model_reset();
        test_reset();
        test_single_read();
        test_fairness();
        test_raw();
        test_random();
        test_reset_midflight();
`ifdef CHIP8_ARB_LOCK_EN
        test_lock();
        test_lock_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Shares the single-port CHIP-8 memory BRAM between up to NUM_REQ requesters over one unified byte address space: RAM, V registers, I, timers, PC and stack.
- Requesters are the processor, the sprite drawer and the display scanout.
- Uses round-robin arbitration with a registered BRAM command stage.
- Read data is routed back to the issuing requester through a tag pipeline matched to the BRAM read latency.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = display, 1 = processor, 2 = sprite drawer.
- ADDR_W, 13, unified address width: 0x0000-0x0FFF RAM, 0x1000-0x10FF regs/stack.
- DATA_W, 8, byte data width.
- RD_LATENCY, 2, BRAM cycles from en/addr to valid dout; legal range 1-3.
- LOCK_MAX, 64, maximum cycles a lock may be held; used only with CHIP8_ARB_LOCK_EN.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous assert, active-low
- req_valid_in  input  [NUM_REQ]  request pending
- req_we_in  input  [NUM_REQ]  1 = write, 0 = read
- req_addr_in  input  [NUM_REQ][ADDR_W]  byte address
- req_data_in  input  [NUM_REQ][DATA_W]  write data
- req_lock_in  input  [NUM_REQ]  hold the grant after this access (optional feature)
- req_ready_out  output  [NUM_REQ]  request accepted this cycle
- rsp_valid_out  output  [NUM_REQ]  read data valid for that requester
- rsp_data_out  output  DATA_W  read data, shared by all requesters
- bram_en_out  output  1  BRAM enable
- bram_we_out  output  1  BRAM write enable
- bram_addr_out  output  ADDR_W  BRAM address
- bram_data_out  output  DATA_W  BRAM write data
- bram_data_in  input  DATA_W  BRAM read data
- error_out  output  1  sticky lock-timeout flag

Behaviour:
- Reset:
  - All outputs are 0.
  - rr_ptr = 0, state = ARB, tag pipeline cleared.
  - Any in-flight reads are discarded and produce no rsp_valid after reset.
- Handshake:
  - A transfer occurs when req_valid_in[i] & req_ready_out[i].
  - At most one req_ready_out bit is high per cycle, computed combinationally from req_valid_in, rr_ptr and state.
  - req_ready_out[i] is never high while req_valid_in[i] = 0.
  - The arbiter always accepts a request in ARB if one exists; no back-pressure from the BRAM.
- Round-robin:
  - The search starts at rr_ptr and wraps modulo NUM_REQ.
  - After a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - With N continuously requesting masters, every master is granted within N cycles.
- Command stage:
  - Handshake in cycle T drives, registered, in cycle T+1: bram_en_out = 1, bram_we_out = we, bram_addr_out, bram_data_out.
  - bram_en_out = 0 on cycles with no handshake in T.
- Reads:
  - A tag {valid, id} enters a pipeline of depth 1+RD_LATENCY at T.
  - rsp_valid_out[id] = 1 for exactly one cycle at T+1+RD_LATENCY.
  - rsp_data_out = bram_data_in in that cycle.
  - One response per cycle at most; responses return strictly in issue order.
- Writes:
  - Writes produce no response.
  - Read-after-write to the same address, by any requester, returns the new data because the BRAM port is in order.
- Back-to-back: a requester may handshake on consecutive cycles and has multiple reads in flight, up to 1+RD_LATENCY.
- States (only when CHIP8_ARB_LOCK_EN is defined): ARB, LOCKED(owner, lock_cnt).
  - ARB -> LOCKED when a handshake has req_lock_in = 1; lock_cnt = 0.
  - In LOCKED, only the owner can be ready.
  - LOCKED -> ARB when the owner handshakes with req_lock_in = 0 (that access is performed).
  - LOCKED -> ARB when the owner has req_lock_in = 0 and req_valid_in = 0 (abandon).
  - LOCKED -> ARB forced when lock_cnt reaches LOCK_MAX-1; error_out <= 1 (sticky until reset).
  - rr_ptr updates on lock release as after a normal grant to the owner.
- Out-of-range addresses are passed through unchanged; range checking is the BRAM wrapper's responsibility.

Optional Feature:
- Macro: CHIP8_ARB_LOCK_EN.
- Defined: the LOCKED state, lock_cnt and error_out are implemented as above. This gives atomic read-modify-write for sprite XOR and collision, and for BCD store.
- Undefined: req_lock_in is ignored, the arbiter stays in ARB, error_out is tied to 0 and lock_cnt is absent.

Decomposition:
- chip8_pkg holds:
  - Address-map constants: RAM_BASE = 0x000, VREG_BASE = 0x1000, IREG_HI/LO = 0x1010/0x1011, DT = 0x1012, ST = 0x1013, PC_HI/LO = 0x1014/0x1015, SP = 0x1016, STACK_BASE = 0x1020.
  - Requester ID constants: REQ_DISP = 0, REQ_CPU = 1, REQ_SPR = 2.
  - The arbiter state enum.
- Sub-module chip8_rr_arbiter: valid vector + rr_ptr + lock mask in, one-hot grant out, next pointer out.

Test Plan:
- Single read: CPU reads 0x200 holding 0xA2 at T -> bram_en and bram_addr = 0x200 at T+1; rsp_valid_out = 3'b010 with data 0xA2 at T+3; no other valid bits.
- Fairness: all three requesters hold valid for 9 cycles with rr_ptr = 0 -> grants 0,1,2,0,1,2,0,1,2; responses tagged in the same order.
- RAW: processor writes 0x55 to 0x1005, then display reads 0x1005 in the next cycle -> display receives 0x55.
- Reset mid-flight: two reads issued, rst_n_in pulsed low for 1 cycle before the data returns -> no rsp_valid_out; all outputs 0 during reset.
- Lock (macro on): sprite drawer reads 0x300 with lock=1 while the CPU requests continuously -> CPU ready stays 0 until the sprite drawer writes 0x300 with lock=0; CPU granted the next cycle.
- Lock timeout (macro on, LOCK_MAX = 64): owner holds lock with valid = 0 and lock = 1 -> forced release after 64 cycles; error_out = 1 and stays 1 until reset.
